// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for a two-digit BCD up-counter: loads the target,
// runs the counter, detects completion, optionally auto-restarts, watches for stalls.
module bcd_count_ctrl #(
  parameter int LOAD_CYCLES = 2,
  parameter int HOLD_CYCLES = 20,
  parameter int WDOG_MARGIN = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  input  logic       repeat_en,
  input  logic [6:0] max_in,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  output logic       run,
  output logic [6:0] max_count,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] pass_count
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, FAULT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [9:0]  wdog_q, wdog_d;
  logic [6:0]  max_q, max_d;
  logic        done_q, done_d;
  logic [7:0]  pass_q, pass_d;

  logic [6:0]  tens, ones;
  logic        hit, load_end, hold_end, wdog_end;

  // Target is always <= 99, so both quotient and remainder fit a BCD nibble.
  assign tens     = max_q / 7'd10;
  assign ones     = max_q % 7'd10;
  assign hit      = ({digit_2, digit_1} == {tens[3:0], ones[3:0]});
  assign load_end = (tmr_q == 8'(LOAD_CYCLES - 1));
  assign hold_end = (tmr_q >= 8'(HOLD_CYCLES - 1));
  assign wdog_end = (wdog_q == ({3'b000, max_q} + 10'(WDOG_MARGIN)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (load_end) state_d = RUN;
      RUN:     if (hit) state_d = DONE;
               else if (wdog_end) state_d = FAULT;
      DONE:    if (start || (repeat_en && hold_end)) state_d = LOAD;
      FAULT:   if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;

    // Shared dwell timer for LOAD and DONE; restarts from 0 on every state change.
    tmr_d = 8'd0;
    if ((state_d == state_q) && ((state_q == LOAD) || (state_q == DONE)) && (tmr_q != 8'hFF))
      tmr_d = tmr_q + 8'd1;

    wdog_d = ((state_q == RUN) && (state_d == RUN)) ? wdog_q + 10'd1 : 10'd0;

    max_d = max_q;
    if ((state_d == LOAD) && (state_q != LOAD))
      max_d = (max_in > 7'd99) ? 7'd99 : max_in;

    done_d = (state_d == DONE) && (state_q != DONE);

    pass_d = pass_q;
    if (abort) pass_d = 8'd0;
    else if (done_d && (pass_q != 8'hFF)) pass_d = pass_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tmr_q   <= 8'd0;
      wdog_q  <= 10'd0;
      max_q   <= 7'd0;
      done_q  <= 1'b0;
      pass_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      wdog_q  <= wdog_d;
      max_q   <= max_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // run stays high in DONE so the counter holds its final value.
  assign run        = (state_q == RUN) || (state_q == DONE);
  assign busy       = (state_q == LOAD) || (state_q == RUN);
  assign fault      = (state_q == FAULT);
  assign done       = done_q;
  assign max_count  = max_q;
  assign pass_count = pass_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl with a behavioural BCD counter attached
// and a scoreboard of expected completions.
module tb_bcd_count_ctrl;

  logic       CLK = 1'b0;
  logic       RST, start, abort, repeat_en;
  logic [6:0] max_in;
  logic [3:0] digit_1, digit_2;
  logic       run, busy, done, fault;
  logic [6:0] max_count;
  logic [7:0] pass_count;

  int vecs = 0;
  int errs = 0;

  typedef struct { int tgt; int lat; } exp_t;
  exp_t sb_q[$];

  // Counter model: clears and captures max while run=0, counts up to it while run=1.
  logic [6:0] cnt, cap;
  logic       stuck;
  always @(posedge CLK) begin
    if (!run) begin
      cnt <= 7'd0;
      cap <= max_count;
    end else if (cnt != cap) begin
      cnt <= cnt + 7'd1;
    end
  end
  assign digit_1 = stuck ? 4'd0 : 4'(cnt % 7'd10);
  assign digit_2 = stuck ? 4'd0 : 4'(cnt / 7'd10);

  bcd_count_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .repeat_en(repeat_en),
    .max_in(max_in), .digit_1(digit_1), .digit_2(digit_2), .run(run),
    .max_count(max_count), .busy(busy), .done(done), .fault(fault),
    .pass_count(pass_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int tgt_in, input int exp_tgt, input int exp_lat);
    exp_t e;
    max_in = 7'(tgt_in);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    e.tgt = exp_tgt;
    e.lat = exp_lat;
    sb_q.push_back(e);
  endtask

  // Waits for run to rise, then for done; optional max_in change mid-RUN.
  task automatic wait_done(input int chg_at, input int chg_val);
    exp_t e;
    int   k;
    e = sb_q.pop_front();
    k = 1;
    while (!run && k < 50) begin tick(); k++; end
    chk("load_len", k, 3);
    k = 0;
    while (!done && k < 300) begin
      tick();
      k++;
      if (k == chg_at) max_in = 7'(chg_val);
    end
    chk("done_lat", k, e.lat);
    chk("max_count", max_count, e.tgt);
    chk("digit_2", digit_2, e.tgt / 10);
    chk("digit_1", digit_1, e.tgt % 10);
    chk("run_in_done", run, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_max"}, max_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_pass"}, pass_count, 0);
  endtask

  initial begin
    int k;
    RST = 1'b1; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    max_in = 7'd0; stuck = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");
    RST = 1'b0;
    tick();

    // Basic pass to 73; change max_in mid-RUN must not matter.
    do_start(73, 73, 74);
    chk("load0_run", run, 0);
    chk("load0_busy", busy, 1);
    wait_done(10, 15);
    chk("pass1", pass_count, 1);
    tick();
    chk("done_one_shot", done, 0);

    // Restart from DONE with the new max_in.
    do_start(15, 15, 16);
    wait_done(0, 0);
    chk("pass2", pass_count, 2);

    // Out-of-range target clamps to 99.
    do_start(118, 99, 100);
    wait_done(0, 0);
    chk("pass3", pass_count, 3);

    // Abort clears pass_count; then auto-repeat with target 5.
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_pass", pass_count, 0);
    chk("abort_run", run, 0);
    repeat_en = 1'b1;
    do_start(5, 5, 6);
    wait_done(0, 0);
    for (int p = 2; p <= 3; p++) begin
      k = 0;
      do begin tick(); k++; end while (!done && k < 100);
      chk("repeat_period", k, 28);
      chk("repeat_pass", pass_count, p);
    end
    repeat_en = 1'b0;
    k = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done) k++; end
    chk("no_repeat_done", k, 0);
    chk("no_repeat_run", run, 1);
    chk("no_repeat_pass", pass_count, 3);

    // Stalled counter with target 10: watchdog trips after wdog reaches 18.
    stuck = 1'b1;
    do_start(10, 10, 0);
    void'(sb_q.pop_front());
    k = 1;
    while (!run && k < 50) begin tick(); k++; end
    k = 0;
    while (run && k < 100) begin tick(); k++; end
    chk("wdog_run_cycles", k, 19);
    chk("fault_set", fault, 1);
    chk("fault_run", run, 0);
    chk("fault_pass", pass_count, 3);
    stuck = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("recover_busy", busy, 1);
    chk("recover_fault", fault, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort2_pass", pass_count, 0);
    chk("abort2_busy", busy, 0);

    // Target 0 completes after one RUN cycle.
    do_start(0, 0, 1);
    wait_done(0, 0);

    // abort wins over start.
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("prio_busy", busy, 0);
    chk("prio_run", run, 0);
    tick();
    chk("prio_idle", busy, 0);

    // Reset in RUN.
    do_start(50, 50, 0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst_run", run, 1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk_reset_vals("rst_run");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
